// File: rtl/player_motion_if.sv
// player_motion_if: tick/key/collision inputs and position/state
// outputs of the blue character's motion controller.
interface player_motion_if;
  logic       tick;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic [3:0] is_Collision;
  logic [9:0] x_blue;
  logic [8:0] y_blue;
  logic [1:0] state_o;
  logic       on_ground;

  modport master (
    output tick,
    output key_left,
    output key_right,
    output key_jump,
    output is_Collision,
    input  x_blue,
    input  y_blue,
    input  state_o,
    input  on_ground
  );

  modport slave (
    input  tick,
    input  key_left,
    input  key_right,
    input  key_jump,
    input  is_Collision,
    output x_blue,
    output y_blue,
    output state_o,
    output on_ground
  );
endinterface

// File: rtl/player_motion.sv
// player_motion: per-tick position and jump FSM for the blue
// character; 1 px per tick per axis, collision-gated.
module player_motion #(
  parameter logic [9:0] X_INIT = 10'd100,
  parameter logic [8:0] Y_INIT = 9'd300,
  parameter logic [9:0] X_MAX  = 10'd617,
  parameter logic [8:0] Y_MAX  = 9'd435,
  parameter logic [5:0] JUMP_H = 6'd40,
  parameter logic [3:0] APEX_T = 4'd4
) (
  input logic             clk,
  input logic             rst_n,
  player_motion_if.slave  bus
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    APEX   = 2'd2,
    FALL   = 2'd3
  } state_t;

  localparam logic [5:0] RISE_LAST = JUMP_H - 6'd1;
  localparam logic [5:0] APEX_LAST = {2'b00, APEX_T - 4'd1};

  state_t     state;
  state_t     state_nx;
  logic [9:0] x;
  logic [9:0] x_nx;
  logic [8:0] y;
  logic [8:0] y_nx;
  logic [5:0] cnt;
  logic [5:0] cnt_nx;
  logic       jump_prev;
  logic       jump_pend;
  logic       jump_now;
  logic       go_l;
  logic       go_r;
  logic       below;
  logic       above;

  // an edge coinciding with a tick is consumed by that tick
  assign jump_now = jump_pend | (bus.key_jump & ~jump_prev);
  assign below    = bus.is_Collision[0];
  assign above    = bus.is_Collision[1];

  assign go_l = bus.key_left & ~bus.key_right
              & ~bus.is_Collision[3] & (x != 10'd0);
  assign go_r = bus.key_right & ~bus.key_left
              & ~bus.is_Collision[2] & (x != X_MAX);

  always_comb begin
    x_nx = x;
    unique case (1'b1)
      go_l:    x_nx = x - 10'd1;
      go_r:    x_nx = x + 10'd1;
      default: x_nx = x;
    endcase
  end

  always_comb begin
    state_nx = state;
    y_nx     = y;
    cnt_nx   = cnt;
    case (state)
      GROUND: begin
        if (jump_now) begin
          if (!above && y != 9'd0) begin
            state_nx = RISE;
            cnt_nx   = 6'd0;
            y_nx     = y - 9'd1;
          end
        end else if (!below && y != Y_MAX) begin
          state_nx = FALL;
        end
      end
      RISE: begin
        if (above || y == 9'd0) begin
          state_nx = FALL;
          cnt_nx   = 6'd0;
        end else begin
          y_nx = y - 9'd1;
          if (cnt + 6'd1 == RISE_LAST) begin
            state_nx = APEX;
            cnt_nx   = 6'd0;
          end else begin
            cnt_nx = cnt + 6'd1;
          end
        end
      end
      APEX: begin
        if (below) begin
          state_nx = GROUND;
          cnt_nx   = 6'd0;
        end else if (cnt == APEX_LAST) begin
          state_nx = FALL;
          cnt_nx   = 6'd0;
        end else begin
          cnt_nx = cnt + 6'd1;
        end
      end
      FALL: begin
        if (below || y == Y_MAX) begin
          state_nx = GROUND;
        end else begin
          y_nx = y + 9'd1;
        end
      end
      default: state_nx = FALL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FALL;
      x         <= X_INIT;
      y         <= Y_INIT;
      cnt       <= 6'd0;
      jump_prev <= 1'b0;
      jump_pend <= 1'b0;
    end else begin
      jump_prev <= bus.key_jump;
      if (bus.tick) begin
        jump_pend <= 1'b0;
        state     <= state_nx;
        x         <= x_nx;
        y         <= y_nx;
        cnt       <= cnt_nx;
      end else if (jump_now) begin
        jump_pend <= 1'b1;
      end
    end
  end

  assign bus.x_blue    = x;
  assign bus.y_blue    = y;
  assign bus.state_o   = state;
  assign bus.on_ground = (state == GROUND);

endmodule
